multi_ball: RTL

MULTI_BALL -- requirements
Module: multi_ball

---
 rtl/multi_ball_pkg.sv | 21 ++
 rtl/multi_ball_ball_step.sv | 84 ++++++++
 rtl/multi_ball.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/multi_ball_pkg.sv
// Shared types and constants for the multi_ball sprite engine.
package multi_ball_pkg;

   localparam int unsigned COORD_W = 13;
   localparam int unsigned IDX_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // lr: 1 = moving right, ud: 1 = moving down
   typedef struct packed {
      logic [COORD_W-1:0] col;
      logic [COORD_W-1:0] row;
      logic               lr;
      logic               ud;
   } ball_t;

endpackage

// File: rtl/multi_ball_ball_step.sv
// ball_step: combinational next-position math for one ball (walls + paddle faces).
module ball_step
   import multi_ball_pkg::*;
#(
   parameter int unsigned RADIUS  = 5,
   parameter int unsigned C_SPEED = 1,
   parameter int unsigned R_SPEED = 1,
   parameter int unsigned COL_MAX = 616,
   parameter int unsigned ROW_MAX = 477
) (
   input  ball_t              ball_in,
   input  logic [COORD_W-1:0] T,
   input  logic [COORD_W-1:0] B,
   input  logic [COORD_W-1:0] L,
   input  logic [COORD_W-1:0] R,
   output ball_t              ball_nxt_c,
   output logic               hit_c
);

   localparam int unsigned AW   = COORD_W + 1;
   localparam logic [AW-1:0] RAD  = AW'(RADIUS);
   localparam logic [AW-1:0] RAD2 = AW'(2 * RADIUS);
   localparam logic [AW-1:0] CSPD = AW'(C_SPEED);
   localparam logic [AW-1:0] RSPD = AW'(R_SPEED);
   localparam logic [AW-1:0] CMAX = AW'(COL_MAX);
   localparam logic [AW-1:0] RMAX = AW'(ROW_MAX);

   // One axis: default step, wall bounce, then paddle faces override the wall.
   // Returns {hit, dir, pos}.
   function automatic logic [COORD_W+1:0] axis_step(
      input logic [COORD_W-1:0] pos,
      input logic               dir,
      input logic [AW-1:0]      spd,
      input logic [AW-1:0]      lim,
      input logic [COORD_W-1:0] lo,
      input logic [COORD_W-1:0] hi,
      input logic               span
   );
      logic [AW-1:0] p, pl, ph, nxt;
      logic          d, hit;
      p   = {1'b0, pos};
      pl  = {1'b0, lo};
      ph  = {1'b0, hi};
      nxt = dir ? (p + spd) : (p - spd);
      d   = dir;
      hit = 1'b0;
      if (dir && ((p + spd + RAD) >= lim)) begin
         nxt = (lim << 1) - p - RAD2 - spd;
         d   = 1'b0;
      end else if (!dir && (p < (spd + RAD))) begin
         nxt = spd - p + RAD2;
         d   = 1'b1;
      end
      // Faces only reflect a ball crossing in from outside the box.
      if (span && dir && ((p + RAD) < pl) && ((p + spd + RAD) >= pl)) begin
         nxt = (pl << 1) - p - RAD2 - spd;
         d   = 1'b0;
         hit = 1'b1;
      end else if (span && !dir && (p > (ph + RAD)) && (p <= (ph + RAD + spd))) begin
         nxt = (ph << 1) + RAD2 + spd - p;
         d   = 1'b1;
         hit = 1'b1;
      end
      return {hit, d, COORD_W'(nxt)};
   endfunction

   logic               row_span, col_span;
   logic [COORD_W+1:0] col_res, row_res;

   // Evaluate both axes independently and assemble the next ball state.
   always_comb begin
      row_span   = (ball_in.row >= T) && (ball_in.row <= B);
      col_span   = (ball_in.col >= L) && (ball_in.col <= R);
      col_res    = axis_step(ball_in.col, ball_in.lr, CSPD, CMAX, L, R, row_span);
      row_res    = axis_step(ball_in.row, ball_in.ud, RSPD, RMAX, T, B, col_span);
      ball_nxt_c = '0;
      ball_nxt_c.col = col_res[COORD_W-1:0];
      ball_nxt_c.lr  = col_res[COORD_W];
      ball_nxt_c.row = row_res[COORD_W-1:0];
      ball_nxt_c.ud  = row_res[COORD_W];
      hit_c      = col_res[COORD_W+1] | row_res[COORD_W+1];
   end

endmodule

// File: rtl/multi_ball.sv
// multi_ball: frame-synchronous updater for NUM_BALLS bouncing balls sharing one ball_step.
// Optional MULTI_BALL_SCORE_EN adds a saturating paddle hit counter output.
module multi_ball
   import multi_ball_pkg::*;
#(
   parameter int unsigned NUM_BALLS = 4,
   parameter int unsigned RADIUS    = 5,
   parameter int unsigned C_SPEED   = 1,
   parameter int unsigned R_SPEED   = 1,
   parameter int unsigned COL_MAX   = 616,
   parameter int unsigned ROW_MAX   = 477
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           sync,
   input  logic [12:0]                    T,
   input  logic [12:0]                    B,
   input  logic [12:0]                    L,
   input  logic [12:0]                    R,
   input  logic                           ld_valid,
   input  logic [3:0]                     ld_idx,
   input  logic [12:0]                    ld_col,
   input  logic [12:0]                    ld_row,
   input  logic [1:0]                     ld_dir,
   output logic [13*NUM_BALLS-1:0]        row_bus,
   output logic [13*NUM_BALLS-1:0]        col_bus,
   output logic                           busy,
   output logic                           done,
`ifdef MULTI_BALL_SCORE_EN
   output logic [15:0]                    hit_count,
`endif
   output logic                           overrun
);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   ball_t            balls [NUM_BALLS];
   ball_t            cur_ball, step_ball;
   logic             step_hit;
   logic             ld_ok;

   assign ld_ok = ld_valid && (state == ST_IDLE);

   // Select the ball addressed by the sweep index.
   always_comb begin
      cur_ball = balls[0];
      for (int i = 0; i < NUM_BALLS; i++) begin
         if (idx == IDX_W'(i)) cur_ball = balls[i];
      end
   end

   ball_step #(
      .RADIUS  (RADIUS),
      .C_SPEED (C_SPEED),
      .R_SPEED (R_SPEED),
      .COL_MAX (COL_MAX),
      .ROW_MAX (ROW_MAX)
   ) u_step (
      .ball_in    (cur_ball),
      .T          (T),
      .B          (B),
      .L          (L),
      .R          (R),
      .ball_nxt_c (step_ball),
      .hit_c      (step_hit)
   );

   // FSM state, sweep index and status flags.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         idx   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         busy  <= (state_nxt != ST_IDLE);
         done  <= (state_nxt == ST_DONE);
      end
   end

   // Next-state: one ball per cycle in UPDATE, single DONE cycle, back to IDLE.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         ST_IDLE: begin
            if (sync) begin
               state_nxt = ST_UPDATE;
               idx_nxt   = '0;
            end
         end
         ST_UPDATE: begin
            if (idx == IDX_W'(NUM_BALLS - 1)) state_nxt = ST_DONE;
            else                              idx_nxt   = idx + IDX_W'(1);
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Sticky flag for a frame pulse that arrives mid-sweep.
   always_ff @(posedge clk) begin
      if (!reset_n)                        overrun <= 1'b0;
      else if (sync && (state != ST_IDLE)) overrun <= 1'b1;
   end

   // Ball state storage: sweep writeback or idle-time preload.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_BALLS; i++) begin
            balls[i].col <= COORD_W'(20 + 40 * i);
            balls[i].row <= COORD_W'(20);
            balls[i].lr  <= ((i % 2) == 0);
            balls[i].ud  <= 1'b1;
         end
      end else begin
         for (int i = 0; i < NUM_BALLS; i++) begin
            if ((state == ST_UPDATE) && (idx == IDX_W'(i))) begin
               balls[i] <= step_ball;
            end else if (ld_ok && (ld_idx == IDX_W'(i))) begin
               balls[i].col <= ld_col;
               balls[i].row <= ld_row;
               balls[i].lr  <= ld_dir[1];
               balls[i].ud  <= ld_dir[0];
            end
         end
      end
   end

   // Flatten ball positions onto the output buses.
   always_comb begin
      row_bus = '0;
      col_bus = '0;
      for (int i = 0; i < NUM_BALLS; i++) begin
         row_bus[COORD_W*i +: COORD_W] = balls[i].row;
         col_bus[COORD_W*i +: COORD_W] = balls[i].col;
      end
   end

`ifdef MULTI_BALL_SCORE_EN
   // Count balls that bounced off the paddle, saturating.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hit_count <= '0;
      end else if ((state == ST_UPDATE) && step_hit && (hit_count != 16'hFFFF)) begin
         hit_count <= hit_count + 16'd1;
      end
   end
`else
   logic unused_hit;
   assign unused_hit = step_hit;
`endif

endmodule
